// File: rtl/seq_priority_encoder.sv
// Multi-cycle priority encoder: snapshots a request vector and scans LANES bits per cycle.
// Optional input mask enabled by defining SEQ_PENC_MASK_EN.
module seq_priority_encoder #(
    parameter int WIDTH = 32,
    parameter int LANES = 4,
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             lsb_first,
    input  logic [WIDTH-1:0] in,
`ifdef SEQ_PENC_MASK_EN
    input  logic [WIDTH-1:0] mask,
`endif
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic [IW-1:0]    index,
    output logic [WIDTH-1:0] onehot
);

    localparam int NG = WIDTH / LANES;
    localparam int PW = (NG > 1) ? $clog2(NG) : 1;
    localparam logic [PW-1:0] PTR_LAST = PW'(NG - 1);

    if ((WIDTH < 2) || (WIDTH % LANES != 0)) begin : g_bad_cfg
        $error("seq_priority_encoder: WIDTH must be >= 2 and a multiple of LANES");
    end

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] req_q;
    logic             dir_q;
    logic [PW-1:0]    ptr_q;
    logic             done_q;
    logic             found_q;
    logic [IW-1:0]    index_q;
    logic [WIDTH-1:0] onehot_q;

    logic [WIDTH-1:0] cap_vec;
    logic [LANES-1:0] grp;
    logic             hit;
    int               sel;
    logic             last;
    logic [IW-1:0]    win_idx;
    logic [WIDTH-1:0] win_oh;

`ifdef SEQ_PENC_MASK_EN
    assign cap_vec = in & mask;
`else
    assign cap_vec = in;
`endif

    // Group select: the last matching lane in loop order wins, so the loop
    // direction decides highest-first versus lowest-first within the group.
    always_comb begin
        grp  = req_q[int'(ptr_q) * LANES +: LANES];
        hit  = 1'b0;
        sel  = 0;
        if (dir_q) begin
            for (int i = LANES - 1; i >= 0; i--) begin
                if (grp[i]) begin
                    hit = 1'b1;
                    sel = i;
                end
            end
        end else begin
            for (int i = 0; i < LANES; i++) begin
                if (grp[i]) begin
                    hit = 1'b1;
                    sel = i;
                end
            end
        end
        win_idx = IW'(int'(ptr_q) * LANES + sel);
        win_oh  = {{(WIDTH-1){1'b0}}, 1'b1} << win_idx;
        last    = dir_q ? (ptr_q == PTR_LAST) : (ptr_q == '0);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SCAN;
            SCAN:    if (hit || last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            req_q    <= '0;
            dir_q    <= 1'b0;
            ptr_q    <= '0;
            done_q   <= 1'b0;
            found_q  <= 1'b0;
            index_q  <= '0;
            onehot_q <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        req_q <= cap_vec;
                        dir_q <= lsb_first;
                        ptr_q <= lsb_first ? '0 : PTR_LAST;
                    end
                end
                SCAN: begin
                    if (hit) begin
                        done_q   <= 1'b1;
                        found_q  <= 1'b1;
                        index_q  <= win_idx;
                        onehot_q <= win_oh;
                    end else if (last) begin
                        done_q   <= 1'b1;
                        found_q  <= 1'b0;
                        index_q  <= '0;
                        onehot_q <= '0;
                    end else begin
                        ptr_q <= dir_q ? ptr_q + 1'b1 : ptr_q - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy   = (state_q == SCAN);
    assign done   = done_q;
    assign found  = found_q;
    assign index  = index_q;
    assign onehot = onehot_q;

endmodule

// File: tb/tb_seq_priority_encoder.sv
// Directed bench for seq_priority_encoder (WIDTH=32, LANES=4); mask case runs when
// SEQ_PENC_MASK_EN is defined.
module tb_seq_priority_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        lsb_first;
    logic [31:0] in;
`ifdef SEQ_PENC_MASK_EN
    logic [31:0] mask;
`endif
    logic        busy;
    logic        done;
    logic        found;
    logic [4:0]  index;
    logic [31:0] onehot;

    int tests_run    = 0;
    int tests_failed = 0;

    seq_priority_encoder #(.WIDTH(32), .LANES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .lsb_first (lsb_first),
        .in        (in),
`ifdef SEQ_PENC_MASK_EN
        .mask      (mask),
`endif
        .busy      (busy),
        .done      (done),
        .found     (found),
        .index     (index),
        .onehot    (onehot)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One complete request; input is scrambled after capture to prove the snapshot.
    task automatic run_scan(input string tag, input logic [31:0] vec, input logic lsb,
                            input int exp_lat, input logic exp_found,
                            input logic [31:0] exp_idx, input logic [31:0] exp_oh);
        int lat;
        @(negedge clk);
        in        = vec;
        lsb_first = lsb;
        start     = 1'b1;
        @(posedge clk); #1;
        check({tag, " busy_after_start"}, 32'(busy), 32'd1);
        @(negedge clk);
        start     = 1'b0;
        in        = ~vec;
        lsb_first = ~lsb;
        lat = 0;
        while (lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (done) break;
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " found"}, 32'(found), 32'(exp_found));
        check({tag, " index"}, 32'(index), exp_idx);
        check({tag, " onehot"}, onehot, exp_oh);
        check({tag, " busy_at_done"}, 32'(busy), 32'd0);
        @(posedge clk); #1;
        check({tag, " done_one_cycle"}, 32'(done), 32'd0);
        check({tag, " index_hold"}, 32'(index), exp_idx);
    endtask

    initial begin
        int ndone;
        rst = 1'b0; start = 1'b0; lsb_first = 1'b0; in = '0;
`ifdef SEQ_PENC_MASK_EN
        mask = 32'hFFFF_FFFF;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset found", 32'(found), 32'd0);
        check("reset index", 32'(index), 32'd0);
        check("reset onehot", onehot, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        run_scan("zero_msb",     32'h0000_0000, 1'b0, 8, 1'b0, 32'd0,  32'h0000_0000);
        run_scan("ends_msb",     32'h8000_0001, 1'b0, 1, 1'b1, 32'd31, 32'h8000_0000);
        run_scan("ends_lsb",     32'h8000_0001, 1'b1, 1, 1'b1, 32'd0,  32'h0000_0001);
        run_scan("mid_msb",      32'h0001_0100, 1'b0, 4, 1'b1, 32'd16, 32'h0001_0000);
        run_scan("mid_lsb",      32'h0001_0100, 1'b1, 3, 1'b1, 32'd8,  32'h0000_0100);
        run_scan("lastgrp_msb",  32'h0000_0001, 1'b0, 8, 1'b1, 32'd0,  32'h0000_0001);
        run_scan("lastgrp_lsb",  32'h8000_0000, 1'b1, 8, 1'b1, 32'd31, 32'h8000_0000);
        run_scan("ingrp_msb",    32'h0000_0600, 1'b0, 6, 1'b1, 32'd10, 32'h0000_0400);
        run_scan("ingrp_lsb",    32'h0000_0600, 1'b1, 3, 1'b1, 32'd9,  32'h0000_0200);
        run_scan("ones_lsb",     32'hFFFF_FFFF, 1'b1, 1, 1'b1, 32'd0,  32'h0000_0001);
        run_scan("zero_lsb",     32'h0000_0000, 1'b1, 8, 1'b0, 32'd0,  32'h0000_0000);

        // start while busy is dropped; start in the done cycle is accepted
        @(negedge clk);
        in = 32'h0000_0010; lsb_first = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        check("b2b busy_e0", 32'(busy), 32'd1);
        @(negedge clk);
        in = 32'hFFFF_FFFF; start = 1'b1;
        @(posedge clk); #1;
        check("b2b no_done_e1", 32'(done), 32'd0);
        check("b2b busy_e1", 32'(busy), 32'd1);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk); #1;
        check("b2b done_e2", 32'(done), 32'd1);
        check("b2b index_e2", 32'(index), 32'd4);
        check("b2b busy_e2", 32'(busy), 32'd0);
        @(negedge clk);
        in = 32'h0000_0008; lsb_first = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        check("b2b done_e3", 32'(done), 32'd0);
        check("b2b busy_e3", 32'(busy), 32'd1);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk); #1;
        check("b2b done_e4", 32'(done), 32'd1);
        check("b2b index_e4", 32'(index), 32'd3);
        check("b2b onehot_e4", onehot, 32'h0000_0008);

        // reset during the 3rd scan cycle of an all-zero scan
        @(negedge clk);
        in = 32'h0; lsb_first = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst done", 32'(done), 32'd0);
        check("midrst found", 32'(found), 32'd0);
        check("midrst index", 32'(index), 32'd0);
        check("midrst onehot", onehot, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        ndone = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        check("midrst no_done", 32'(ndone), 32'd0);

`ifdef SEQ_PENC_MASK_EN
        mask = 32'h0000_00F0;
        run_scan("mask_msb", 32'hFFFF_FFFF, 1'b0, 7, 1'b1, 32'd7, 32'h0000_0080);
        mask = 32'h0000_0000;
        run_scan("mask_all", 32'hFFFF_FFFF, 1'b1, 8, 1'b0, 32'd0, 32'h0000_0000);
        mask = 32'hFFFF_FFFF;
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
